// File: rtl/sram_controller.sv
// Synchronous valid/ready front end for an asynchronous single-port SRAM: sequences CE/WE/OE and owns the data bus.
// Define SRAM_CONTROLLER_CLEAR_EN to zero-fill the whole array after every reset before accepting requests.
module sram_controller #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_address,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_chip_enable,
    output logic                  sram_write_enable,
    output logic                  sram_output_enable
);

    localparam int COUNT_WIDTH = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [COUNT_WIDTH-1:0] WAIT_LOAD = COUNT_WIDTH'(WAIT_CYCLES - 1);

`ifdef SRAM_CONTROLLER_CLEAR_EN
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, CLEAR} state_t;
    localparam state_t RESET_STATE = CLEAR;
    logic [ADDR_WIDTH:0] clear_count, clear_count_d;
`else
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t                  state, state_d;
    logic [COUNT_WIDTH-1:0]  wait_count, wait_count_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    drive_q, drive_d;
    logic                    ce_q, ce_d, we_q, we_d, oe_q, oe_d;
    logic                    rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    assign req_ready          = (state == IDLE) && !reset;
    assign rsp_rdata          = rdata_q;
    assign sram_address       = address_q;
    assign sram_chip_enable   = ce_q;
    assign sram_write_enable  = we_q;
    assign sram_output_enable = oe_q;
    // The bus is only ever driven for writes, so OE (low only on reads) never meets a driven bus.
    assign sram_data          = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_d      = state;
        wait_count_d = wait_count;
        write_d      = write_q;
        address_d    = address_q;
        wdata_d      = wdata_q;
        drive_d      = drive_q;
        ce_d         = ce_q;
        we_d         = we_q;
        oe_d         = oe_q;
        rsp_valid_d  = 1'b0;
        rdata_d      = rdata_q;
`ifdef SRAM_CONTROLLER_CLEAR_EN
        clear_count_d = clear_count;
`endif
        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    write_d   = req_write;
                    address_d = req_address;
                    wdata_d   = req_wdata;
                    drive_d   = req_write;
                    ce_d      = 1'b0;
                    oe_d      = req_write;
                    state_d   = SETUP;
                end
            end
`ifdef SRAM_CONTROLLER_CLEAR_EN
            CLEAR: begin
                write_d   = 1'b1;
                address_d = clear_count[ADDR_WIDTH-1:0];
                wdata_d   = '0;
                drive_d   = 1'b1;
                ce_d      = 1'b0;
                oe_d      = 1'b1;
                state_d   = SETUP;
            end
`endif
            SETUP: begin
                wait_count_d = WAIT_LOAD;
                we_d         = !write_q;
                state_d      = STROBE;
            end
            STROBE: begin
                if (wait_count == '0) begin
                    we_d = 1'b1;
                    oe_d = 1'b1;
                    if (!write_q) begin
                        rsp_valid_d = 1'b1;
                        rdata_d     = sram_data;
                    end
                    state_d = HOLD;
                end else begin
                    wait_count_d = wait_count - 1'b1;
                end
            end
            HOLD: begin
                ce_d    = 1'b1;
                drive_d = 1'b0;
                state_d = IDLE;
`ifdef SRAM_CONTROLLER_CLEAR_EN
                // The extra counter bit parks at 2^ADDR_WIDTH once the walk is done.
                if (!clear_count[ADDR_WIDTH]) begin
                    clear_count_d = clear_count + 1'b1;
                    if (clear_count[ADDR_WIDTH-1:0] != '1) state_d = CLEAR;
                end
`endif
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state      <= RESET_STATE;
            wait_count <= '0;
            write_q    <= 1'b0;
            address_q  <= '0;
            wdata_q    <= '0;
            drive_q    <= 1'b0;
            ce_q       <= 1'b1;
            we_q       <= 1'b1;
            oe_q       <= 1'b1;
            rsp_valid  <= 1'b0;
            rdata_q    <= '0;
`ifdef SRAM_CONTROLLER_CLEAR_EN
            clear_count <= '0;
`endif
        end else begin
            state      <= state_d;
            wait_count <= wait_count_d;
            write_q    <= write_d;
            address_q  <= address_d;
            wdata_q    <= wdata_d;
            drive_q    <= drive_d;
            ce_q       <= ce_d;
            we_q       <= we_d;
            oe_q       <= oe_d;
            rsp_valid  <= rsp_valid_d;
            rdata_q    <= rdata_d;
`ifdef SRAM_CONTROLLER_CLEAR_EN
            clear_count <= clear_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: lane 0 runs WAIT_CYCLES=2, lane 1 runs WAIT_CYCLES=1, each with its own SRAM model.
// Expected data comes from a reference memory array; timing from the access-phase rules (occupancy W+3, strobe W).
module tb_sram_controller;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]  reset, req_valid, req_write;
    logic [7:0]  req_address [2];
    logic [15:0] req_wdata   [2];
    wire  [1:0]  req_ready, rsp_valid, ce_n, we_n, oe_n;
    wire  [15:0] rsp_rdata    [2];
    wire  [7:0]  sram_address [2];

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int W = (g == 0) ? 2 : 1;
        wire  [15:0] sram_data;
        logic [15:0] mem [256];
        int          viol = 0;
        logic        prev_ce_low = 1'b0, prev_oe_high = 1'b1;
        logic [7:0]  prev_addr = '0;
        logic [15:0] prev_data = '0;

        sram_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(W)) dut (
            .clock(clock), .reset(reset[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
            .req_address(req_address[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
            .sram_address(sram_address[g]), .sram_data(sram_data),
            .sram_chip_enable(ce_n[g]), .sram_write_enable(we_n[g]), .sram_output_enable(oe_n[g])
        );

        // Asynchronous SRAM: drives on CE&OE low, latches on the rising edge of WE.
        assign sram_data = (!ce_n[g] && !oe_n[g]) ? mem[sram_address[g]] : 16'bz;
        always @(posedge we_n[g]) if (!ce_n[g]) mem[sram_address[g]] <= sram_data;

        always @(negedge clock) begin
            if (!we_n[g] && !oe_n[g]) viol <= viol + 1;
            if (!ce_n[g] && prev_ce_low && sram_address[g] != prev_addr) viol <= viol + 1;
            if (!ce_n[g] && oe_n[g] && prev_ce_low && prev_oe_high && sram_data != prev_data) viol <= viol + 1;
            if (!ce_n[g] && !oe_n[g] && sram_data != mem[sram_address[g]]) viol <= viol + 1;
            prev_ce_low  <= !ce_n[g];
            prev_oe_high <= oe_n[g];
            prev_addr    <= sram_address[g];
            prev_data    <= sram_data;
        end
    end

    int          n_checks = 0, n_fail = 0;
    logic [15:0] ref_mem [2][256];
    bit          ref_ok  [2][256];
    logic [15:0] last_rd [2];
    bit          last_ok [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int s);
        return (s == 0) ? 2 : 1;
    endfunction

    // Holds reset for the given edges, checks reset values, releases, and waits for req_ready.
    task automatic do_reset(input int s, input int cycles);
        int n, bound, expect_n, spurious;
        reset[s] = 1'b1;
        req_valid[s] = 1'b0;
        repeat (cycles) @(posedge clock);
        @(negedge clock);
        check($sformatf("rst_ce_l%0d", s), ce_n[s], 1);
        check($sformatf("rst_we_l%0d", s), we_n[s], 1);
        check($sformatf("rst_oe_l%0d", s), oe_n[s], 1);
        check($sformatf("rst_rsp_valid_l%0d", s), rsp_valid[s], 0);
        check($sformatf("rst_rdata_l%0d", s), rsp_rdata[s], 0);
        check($sformatf("rst_addr_l%0d", s), sram_address[s], 0);
        check($sformatf("rst_ready_l%0d", s), req_ready[s], 0);
        reset[s] = 1'b0;
`ifdef SRAM_CONTROLLER_CLEAR_EN
        expect_n = 256 * (wait_of(s) + 3);
`else
        expect_n = 1;
`endif
        bound = expect_n + 50;
        n = 0;
        spurious = 0;
        do begin
            @(negedge clock);
            n++;
            if (rsp_valid[s]) spurious++;
        end while (!req_ready[s] && n < bound);
        check($sformatf("ready_after_reset_l%0d", s), n, expect_n);
        check($sformatf("no_rsp_after_reset_l%0d", s), spurious, 0);
`ifdef SRAM_CONTROLLER_CLEAR_EN
        for (int i = 0; i < 256; i++) begin
            ref_mem[s][i] = 16'h0000;
            ref_ok[s][i]  = 1'b1;
        end
`endif
        last_rd[s] = 16'h0000;
        last_ok[s] = 1'b1;
    endtask

    // One access from a negedge to the negedge on which req_ready should be back.
    task automatic access(input int s, input bit wr, input logic [7:0] a, input logic [15:0] d, input bit hold);
        int w, n, ready_k, rsp_k, rsp_cnt, we_cnt, oe_cnt;
        logic [15:0] got;
        w = wait_of(s);
        if (last_ok[s]) check($sformatf("rdata_held_l%0d", s), rsp_rdata[s], last_rd[s]);
        req_write[s] = wr;
        req_address[s] = a;
        req_wdata[s] = d;
        req_valid[s] = 1'b1;
        n = 0;
        while (!req_ready[s] && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready[s]) begin
            check($sformatf("ready_timeout_l%0d", s), 0, 1);
            req_valid[s] = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        req_valid[s] = hold;
        req_write[s] = 1'($urandom);
        req_address[s] = 8'($urandom);
        req_wdata[s] = 16'($urandom);
        ready_k = 0; rsp_k = 0; rsp_cnt = 0; we_cnt = 0; oe_cnt = 0; got = '0;
        for (int k = 1; k <= w + 3; k++) begin
            @(negedge clock);
            if (req_ready[s] && ready_k == 0) ready_k = k;
            if (rsp_valid[s]) begin
                rsp_cnt++;
                rsp_k = k;
                got = rsp_rdata[s];
            end
            if (!we_n[s]) we_cnt++;
            if (!oe_n[s]) oe_cnt++;
        end
        check($sformatf("occupancy_l%0d_%s_%02h", s, wr ? "wr" : "rd", a), ready_k, w + 3);
        if (wr) begin
            check($sformatf("we_low_cycles_l%0d_%02h", s, a), we_cnt, w);
            check($sformatf("no_rsp_on_write_l%0d_%02h", s, a), rsp_cnt, 0);
            ref_mem[s][a] = d;
            ref_ok[s][a] = 1'b1;
        end else begin
            check($sformatf("oe_low_cycles_l%0d_%02h", s, a), oe_cnt, w + 1);
            check($sformatf("rsp_pulses_l%0d_%02h", s, a), rsp_cnt, 1);
            check($sformatf("rsp_cycle_l%0d_%02h", s, a), rsp_k, w + 2);
            if (ref_ok[s][a]) begin
                check($sformatf("rdata_l%0d_%02h", s, a), got, ref_mem[s][a]);
                last_rd[s] = ref_mem[s][a];
                last_ok[s] = 1'b1;
            end else begin
                last_ok[s] = 1'b0;
            end
        end
    endtask

    task automatic random_ops(input int s, input int count);
        for (int i = 0; i < count; i++)
            access(s, 1'($urandom), 8'($urandom_range(0, 31)), 16'($urandom), 1'($urandom));
        req_valid[s] = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset = 2'b11;
        req_valid = 2'b00;
        req_write = 2'b00;
        for (int s = 0; s < 2; s++) begin
            req_address[s] = '0;
            req_wdata[s] = '0;
            last_rd[s] = '0;
            last_ok[s] = 1'b0;
        end
        do_reset(0, 3);
        do_reset(1, 3);

        access(0, 1'b1, 8'h10, 16'hBEEF, 1'b0);
        access(0, 1'b0, 8'h10, 16'h0000, 1'b0);

        access(0, 1'b1, 8'h01, 16'h1111, 1'b1);
        access(0, 1'b1, 8'h02, 16'h2222, 1'b1);
        access(0, 1'b0, 8'h01, 16'h0000, 1'b1);
        access(0, 1'b0, 8'h02, 16'h0000, 1'b0);

        // Read of 0x20 abandoned by a reset asserted during its first STROBE cycle.
        req_write[0] = 1'b0;
        req_address[0] = 8'h20;
        req_valid[0] = 1'b1;
        @(posedge clock);
        #1 req_valid[0] = 1'b0;
        @(posedge clock);
        #1 check("mid_reset_in_read_strobe", oe_n[0], 0);
        do_reset(0, 1);

        access(1, 1'b1, 8'hFF, 16'hA5A5, 1'b0);
        access(1, 1'b0, 8'hFF, 16'h0000, 1'b0);

`ifdef SRAM_CONTROLLER_CLEAR_EN
        access(0, 1'b1, 8'h80, 16'h5555, 1'b0);
        access(0, 1'b0, 8'h80, 16'h0000, 1'b0);
        do_reset(0, 2);
        access(0, 1'b0, 8'h80, 16'h0000, 1'b0);
`endif

        random_ops(0, 60);
        random_ops(1, 40);
        repeat (4) @(negedge clock);

        check("protocol_violations_l0", lane[0].viol, 0);
        check("protocol_violations_l1", lane[1].viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Synchronous front end for the asynchronous single-port `sram` model. It accepts one read or write request at a time over a valid/ready handshake and sequences the SRAM's active-low `chip_enable`, `write_enable` and `output_enable` with setup, strobe and hold phases. It also owns the tristate drive of the shared data bus. It sits directly upstream of `sram`, and its `sram_*` pins wire one-to-one onto that module's ports.

## Interface
- `DATA_WIDTH`, 16: data bus width; must match `sram`.
- `ADDR_WIDTH`, 8: address width; must match `sram`.
- `WAIT_CYCLES`, 2: strobe length in clocks; minimum 1.

Ports:
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_address` in ADDR_WIDTH: target address.
- `req_wdata` in DATA_WIDTH: write data.
- `rsp_valid` out 1: one-cycle pulse when read data is valid.
- `rsp_rdata` out DATA_WIDTH: last read data; held between reads.
- `sram_address` out ADDR_WIDTH: to `sram.address`.
- `sram_data` inout DATA_WIDTH: to `sram.data`.
- `sram_chip_enable` out 1: active low.
- `sram_write_enable` out 1: active low.
- `sram_output_enable` out 1: active low.

## Operation
- **FSM states:** IDLE, SETUP, STROBE, HOLD (plus CLEAR, see Configuration).
- **Handshake:** a request is accepted on an edge where `req_valid && req_ready`. Address, data and direction are latched into registers at acceptance.
- **`req_ready`:** high only in IDLE while `reset` is low.
- **IDLE → SETUP on accept.**
  - Write: drive the address and data bus; CE=0, WE=1, OE=1.
  - Read: drive the address; CE=0, OE=0, WE=1; bus released to z.
- **SETUP → STROBE.**
  - Write: WE=0.
  - Read: unchanged.
  - The wait counter loads `WAIT_CYCLES-1`, decrements each cycle, and the FSM leaves STROBE when the count reaches 0.
  - Read: `sram_data` is captured into `rsp_rdata` on the last STROBE edge.
- **STROBE → HOLD.**
  - Write: WE=1; address and data still driven; CE=0.
  - Read: OE=1, CE=0.
  - Read only: `rsp_valid`=1 for exactly this cycle.
- **HOLD → IDLE:** CE=1, bus z, address holds its last value.
- **Bus contention rule:** `sram_data` is driven only in the SETUP, STROBE and HOLD states of a write. OE is never low while the bus is driven.
- **Signal stability:** address and write data never change while CE is low.
- **Strobe sequencing:** WE and OE are never low together.
- **Back-to-back requests:** not pipelined. A held `req_valid` is accepted in the first IDLE cycle after HOLD.

## Timing
- **Reset values** (registered outputs, taking effect on the reset edge):
  - `req_ready`=0 while reset is high.
  - `rsp_valid`=0, `rsp_rdata`=0.
  - `sram_address`=0.
  - CE=WE=OE=1.
  - `sram_data`=z.
  - State = IDLE (or CLEAR if enabled).
- **Write latency:** with acceptance at edge T, SETUP is T+1, STROBE is T+2..T+1+W, HOLD is T+2+W, and IDLE is T+3+W. `req_ready` rises at T+3+W.
- **Read latency:** `rsp_valid` is high at cycle T+2+W, with `rsp_rdata` valid from the same edge.
- **Occupancy:** with default W=2, each access takes 5 cycles from acceptance to the next `req_ready`.
- **Reset mid-access:** on the next edge, all strobes go high and the bus goes z. The access is abandoned; no `rsp_valid` is issued and memory contents at that address are undefined.
- **Inputs while busy:** `req_*` values are ignored while `req_ready`=0.

## Configuration
- **Macro:** `SRAM_CONTROLLER_CLEAR_EN`.
- **When defined:** after reset falls, the FSM enters CLEAR and writes 0 to every address from 0 to 2^ADDR_WIDTH-1 in ascending order.
  - Each write uses the normal SETUP/STROBE/HOLD timing.
  - `req_ready` stays 0 until the final HOLD completes; the FSM then goes to IDLE.
  - The address counter is ADDR_WIDTH+1 bits wide, so the walk terminates and does not wrap.
  - Reset during CLEAR restarts the walk at 0.
- **When undefined:** the CLEAR state and counter are absent, and the FSM leaves reset directly in IDLE with `req_ready`=1.

## Test plan
- **Reset:** hold reset 3 cycles → all strobes 1, bus z, `rsp_valid`=0, `rsp_rdata`=0x0000; `req_ready`=1 in the first cycle after reset (macro off).
- **Write then read:** write 0xBEEF to 0x10, then read 0x10 (W=2) → WE low for exactly 2 cycles with address 0x10 stable; read `rsp_valid` pulses once at T+4 with `rsp_rdata`=0xBEEF; `req_ready` returns at T+5.
- **Back-to-back:** hold `req_valid` for writes 0x01→0x1111 and 0x02→0x2222, then reads of both → 0x1111 and 0x2222 returned; a protocol checker flags no WE/OE overlap and no driven bus with OE low.
- **Reset mid-access:** assert reset during the STROBE of a read of 0x20 → next edge has CE=OE=1, no `rsp_valid`, and `req_ready`=1 after release.
- **WAIT_CYCLES=1 boundary:** write then read 0xFF ↔ 0xA5A5 → 4-cycle occupancy; data 0xA5A5 correct at the top address.
- **Clear walk (`SRAM_CONTROLLER_CLEAR_EN` defined):** preload 0x5555 at 0x80, then reset → `req_ready` low for 256×5 cycles; a subsequent read of 0x80 returns 0x0000.
